// File: rtl/sta_counter.sv
// rtl/sta_counter.sv - gate-level loadable up-counter with registered carry-out, built from INV/AND2/XOR2/DFF cells
module sta_counter #(
    parameter int WIDTH = 8
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LD,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] Q,
    output logic             CO
);
    logic             rst_n;
    logic             ld_n;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] ld_term;
    logic [WIDTH-1:0] inc_term;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] d;
    logic             co_pre;
    logic             co_d;

    INV u_inv_rst (.A(RST), .Y(rst_n));
    INV u_inv_ld  (.A(LD),  .Y(ld_n));

    assign c[0] = EN;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // Ripple chain kept linear so the critical path grows with WIDTH.
        AND2 u_chain  (.A(c[i]),    .B(Q[i]),     .Y(c[i+1]));
        XOR2 u_inc    (.A(Q[i]),    .B(c[i]),     .Y(inc[i]));
        AND2 u_ld     (.A(LD),      .B(DIN[i]),   .Y(ld_term[i]));
        AND2 u_keep   (.A(ld_n),    .B(inc[i]),   .Y(inc_term[i]));
        // Terms are mutually exclusive, so XOR2 behaves as OR here.
        XOR2 u_mux    (.A(ld_term[i]), .B(inc_term[i]), .Y(m[i]));
        AND2 u_rst    (.A(m[i]),    .B(rst_n),    .Y(d[i]));
        DFF  u_ff     (.CK(CK),     .D(d[i]),     .Q(Q[i]));
    end

    AND2 u_co_ld  (.A(c[WIDTH]), .B(ld_n),  .Y(co_pre));
    AND2 u_co_rst (.A(co_pre),   .B(rst_n), .Y(co_d));
    DFF  u_co_ff  (.CK(CK),      .D(co_d),  .Q(CO));
endmodule

module INV (
    input  logic A,
    output logic Y
);
    assign Y = ~A;
endmodule

module AND2 (
    input  logic A,
    input  logic B,
    output logic Y
);
    assign Y = A & B;
endmodule

module XOR2 (
    input  logic A,
    input  logic B,
    output logic Y
);
    assign Y = A ^ B;
endmodule

module DFF (
    input  logic CK,
    input  logic D,
    output logic Q
);
    always_ff @(posedge CK) begin
        Q <= D;
    end
endmodule

// File: tb/tb_sta_counter.sv
// tb/tb_sta_counter.sv - vector table and scoreboard bench for sta_counter at WIDTH=8 and WIDTH=2
module tb_sta_counter;
    logic       clk = 1'b0;
    logic       rst, en, ld;
    logic [7:0] din;
    logic [7:0] q;
    logic       co;
    logic       rst2, en2, ld2;
    logic [1:0] din2;
    logic [1:0] q2;
    logic       co2;

    int passed = 0;
    int total  = 0;

    sta_counter #(.WIDTH(8)) dut (
        .CK(clk), .RST(rst), .EN(en), .LD(ld), .DIN(din), .Q(q), .CO(co)
    );

    sta_counter #(.WIDTH(2)) dut2 (
        .CK(clk), .RST(rst2), .EN(en2), .LD(ld2), .DIN(din2), .Q(q2), .CO(co2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       ld;
        logic [7:0] din;
        logic [7:0] q;
        logic       co;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic       co;
        int         idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t sb2[$];

    task automatic add(input logic r, input logic e, input logic l,
                       input logic [7:0] dv, input logic [7:0] eq, input logic ec);
        vec_t v;
        v.rst = r; v.en = e; v.ld = l; v.din = dv; v.q = eq; v.co = ec;
        vecs.push_back(v);
    endtask

    task automatic check_q(input string name, input int idx,
                           input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d] Q got %h expected %h", name, idx, act, exp);
    endtask

    task automatic check_co(input string name, input int idx,
                            input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d] CO got %b expected %b", name, idx, act, exp);
    endtask

    task automatic pop_w8;
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL w8 scoreboard empty");
        end else begin
            e = sb.pop_front();
            check_q("w8", e.idx, q, e.q);
            check_co("w8", e.idx, co, e.co);
        end
    endtask

    task automatic pop_w2;
        exp_t e;
        if (sb2.size() == 0) begin
            total++;
            $display("FAIL w2 scoreboard empty");
        end else begin
            e = sb2.pop_front();
            check_q("w2", e.idx, {6'd0, q2}, e.q);
            check_co("w2", e.idx, co2, e.co);
        end
    endtask

    task automatic step2(input logic r, input logic e, input logic l,
                         input logic [1:0] dv, input logic [1:0] eq,
                         input logic ec, input int idx);
        exp_t x;
        @(negedge clk);
        rst2 = r; en2 = e; ld2 = l; din2 = dv;
        x.q = {6'd0, eq}; x.co = ec; x.idx = idx;
        sb2.push_back(x);
        @(posedge clk);
        #1;
        pop_w2();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t       x;
        logic [1:0] mq;
        logic       mco;

        rst = 1'b0; en = 1'b0; ld = 1'b0; din = 8'h00;
        rst2 = 1'b1; en2 = 1'b0; ld2 = 1'b0; din2 = 2'd0;

        //   rst   en    ld    din    q      co
        add(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        add(1'b1, 1'b1, 1'b1, 8'hAA, 8'h00, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'h04, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'h05, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'hFE, 8'hFE, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0);
        add(1'b0, 1'b1, 1'b1, 8'h10, 8'h10, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
        add(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0);
        add(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        add(1'b0, 1'b1, 1'b1, 8'h79, 8'h79, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'h7A, 1'b0);
        add(1'b1, 1'b1, 1'b1, 8'h55, 8'h00, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'h80, 8'h80, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'h81, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'h7F, 8'h7F, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'h80, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; en = vecs[i].en; ld = vecs[i].ld; din = vecs[i].din;
            x.q = vecs[i].q; x.co = vecs[i].co; x.idx = i;
            sb.push_back(x);
            @(posedge clk);
            #1;
            pop_w8();
        end

        // WIDTH=2: continuous count after reset, expected values from a small model.
        @(negedge clk);
        en = 1'b0; ld = 1'b0; rst = 1'b0;
        step2(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 0);
        mq = 2'd0;
        for (int k = 1; k <= 9; k++) begin
            mco = (mq == 2'd3);
            mq  = mq + 2'd1;
            step2(1'b0, 1'b1, 1'b0, 2'd0, mq, mco, k);
        end

        // WIDTH=2 corners: load at max with enable, then wrap and hold at zero.
        step2(1'b0, 1'b1, 1'b1, 2'd3, 2'd3, 1'b0, 10);
        step2(1'b0, 1'b1, 1'b1, 2'd2, 2'd2, 1'b0, 11);
        step2(1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 1'b0, 12);
        step2(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 13);
        step2(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 14);
        step2(1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
